// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the instruction FIFO.
package fifo_pkg;

  localparam int DEF_I_WIDTH   = 12;
  localparam int DEF_A_WIDTH   = 8;
  localparam int DEF_LG_DEPTH  = 2;
  localparam int DEF_AF_MARGIN = 1;

  // The count (and each pointer) needs one extra bit so a full FIFO is distinct from an empty one.
  function automatic int count_width(input int lg_depth);
    return lg_depth + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: async reset, synchronous clear, increment enable.
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Clear wins over increment; natural overflow gives the modulo-2*DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/inst_fifo.sv
// Instruction/address FIFO, first-word-fall-through, full DEPTH capacity.
module inst_fifo
  import fifo_pkg::*;
#(
  parameter int I_WIDTH   = DEF_I_WIDTH,
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int LG_DEPTH  = DEF_LG_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [A_WIDTH-1:0]  inst_addr_i,
  input  logic [I_WIDTH-1:0]  inst_data_i,
  input  logic                enque_i,
  input  logic                deque_i,
  input  logic                clear_i,
  output logic [A_WIDTH-1:0]  inst_addr_o,
  output logic [I_WIDTH-1:0]  inst_data_o,
  output logic                valid_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                almost_full_o,
  output logic [LG_DEPTH:0]   count_o,
  output logic                error_o
);

  localparam int DEPTH = 2 ** LG_DEPTH;
  localparam int CW    = count_width(LG_DEPTH);
  localparam logic [CW-1:0] C_AF_LVL = CW'(DEPTH - AF_MARGIN);

  logic [A_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [I_WIDTH-1:0] r_data_mem [DEPTH];
  logic [CW-1:0]      r_count;
  logic               r_err;

  logic [CW-1:0]      w_rptr;
  logic [CW-1:0]      w_wptr;
  logic               w_empty;
  logic               w_full;
  logic               w_acc_enq;
  logic               w_acc_deq;
  logic               w_rej_enq;
  logic               w_rej_deq;
  logic               w_wr;

  // Equal pointers mean empty; differing only in the wrap bit means full.
  assign w_empty = (w_rptr == w_wptr);
  assign w_full  = (w_rptr[LG_DEPTH] != w_wptr[LG_DEPTH]) &&
                   (w_rptr[LG_DEPTH-1:0] == w_wptr[LG_DEPTH-1:0]);

  assign w_acc_deq = deque_i & ~w_empty;
  assign w_acc_enq = enque_i & (~w_full | w_acc_deq);
  assign w_rej_enq = enque_i & ~w_acc_enq;
  // A dequeue on empty paired with an enqueue is a legal "no bypass" cycle, not misuse.
  assign w_rej_deq = deque_i & w_empty & ~enque_i;
  assign w_wr      = w_acc_enq & ~clear_i;

  fifo_ptr #(.W(CW)) u_rd_ptr (
    .clk   (clk),
    .rst   (reset_i),
    .i_clr (clear_i),
    .i_inc (w_acc_deq),
    .o_ptr (w_rptr)
  );

  fifo_ptr #(.W(CW)) u_wr_ptr (
    .clk   (clk),
    .rst   (reset_i),
    .i_clr (clear_i),
    .i_inc (w_acc_enq),
    .o_ptr (w_wptr)
  );

  // Storage write; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_addr_mem[w_wptr[LG_DEPTH-1:0]] <= inst_addr_i;
      r_data_mem[w_wptr[LG_DEPTH-1:0]] <= inst_data_i;
    end
  end

  // Occupancy tracks accepted enqueues minus accepted dequeues.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(w_acc_enq) - CW'(w_acc_deq);
    end
  end

  // Sticky misuse flag, released only by reset or clear.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_err <= 1'b0;
    end else if (clear_i) begin
      r_err <= 1'b0;
    end else if (w_rej_enq || w_rej_deq) begin
      r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only trace of rejected requests.
  always @(posedge clk) begin
    if (!reset_i && !clear_i) begin
      if (w_rej_enq) $display("%0t inst_fifo: enqueue rejected, fifo full", $time);
      if (w_rej_deq) $display("%0t inst_fifo: dequeue rejected, fifo empty", $time);
    end
  end
`endif

  assign inst_addr_o   = r_addr_mem[w_rptr[LG_DEPTH-1:0]];
  assign inst_data_o   = r_data_mem[w_rptr[LG_DEPTH-1:0]];
  assign empty_o       = w_empty;
  assign valid_o       = ~w_empty;
  assign full_o        = w_full;
  assign almost_full_o = (r_count >= C_AF_LVL);
  assign count_o       = r_count;
  assign error_o       = r_err;

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: queue-based model plus directed scenarios.
module tb_inst_fifo;

  localparam int DEPTH = 4;
  localparam int AF    = 1;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  inst_addr_i = '0;
  logic [11:0] inst_data_i = '0;
  logic        enque_i = 1'b0;
  logic        deque_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [7:0]  inst_addr_o;
  logic [11:0] inst_data_o;
  logic        valid_o, empty_o, full_o, almost_full_o, error_o;
  logic [2:0]  count_o;

  inst_fifo #(.I_WIDTH(12), .A_WIDTH(8), .LG_DEPTH(2), .AF_MARGIN(AF)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .inst_addr_i   (inst_addr_i),
    .inst_data_i   (inst_data_i),
    .enque_i       (enque_i),
    .deque_i       (deque_i),
    .clear_i       (clear_i),
    .inst_addr_o   (inst_addr_o),
    .inst_data_o   (inst_data_o),
    .valid_o       (valid_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .count_o       (count_o),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of {addr,data}; plus sticky error.
  logic [19:0] m_q[$];
  bit          m_err = 1'b0;
  int          m_sz;
  bit          m_ad, m_ae;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_q.delete();
      m_err = 1'b0;
    end else if (clear_i) begin
      m_q.delete();
      m_err = 1'b0;
    end else begin
      m_sz = m_q.size();
      m_ad = deque_i && (m_sz > 0);
      m_ae = enque_i && ((m_sz < DEPTH) || m_ad);
      if ((enque_i && !m_ae) || (deque_i && m_sz == 0 && !enque_i)) m_err = 1'b1;
      if (m_ad) void'(m_q.pop_front());
      if (m_ae) m_q.push_back({inst_addr_i, inst_data_i});
    end
  end

  // Compare process: DUT outputs depend only on registered state, so sample mid-cycle.
  always @(negedge clk) begin
    if (chk_en && !reset_i) begin
      chk("count", 32'(count_o), 32'(m_q.size()));
      chk("empty", 32'(empty_o), 32'(m_q.size() == 0));
      chk("valid", 32'(valid_o), 32'(m_q.size() != 0));
      chk("full", 32'(full_o), 32'(m_q.size() == DEPTH));
      chk("almost_full", 32'(almost_full_o), 32'(m_q.size() >= DEPTH - AF));
      chk("error", 32'(error_o), 32'(m_err));
      if (m_q.size() > 0) begin
        chk("head_addr", 32'(inst_addr_o), 32'(m_q[0][19:12]));
        chk("head_data", 32'(inst_data_o), 32'(m_q[0][11:0]));
      end
    end
  end

  task automatic step(input logic enq, input logic deq, input logic clr,
                      input logic [7:0] a, input logic [11:0] d);
    @(negedge clk);
    enque_i = enq; deque_i = deq; clear_i = clr;
    inst_addr_i = a; inst_data_i = d;
    @(posedge clk);
    #1;
    enque_i = 1'b0; deque_i = 1'b0; clear_i = 1'b0;
  endtask

  int  sent;
  bit  r_e, r_d;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_af", 32'(almost_full_o), 0);
    chk("rst_err", 32'(error_o), 0);
    reset_i = 1'b0;
    chk_en = 1'b1;

    // Fill
    step(1, 0, 0, 8'h10, 12'h100);
    chk("fill1_valid", 32'(valid_o), 1);
    chk("fill1_head", 32'(inst_addr_o), 32'h10);
    step(1, 0, 0, 8'h11, 12'h101);
    chk("fill2_af", 32'(almost_full_o), 0);
    step(1, 0, 0, 8'h12, 12'h102);
    chk("fill3_af", 32'(almost_full_o), 1);
    chk("fill3_full", 32'(full_o), 0);
    step(1, 0, 0, 8'h13, 12'h103);
    chk("fill4_full", 32'(full_o), 1);
    chk("fill4_count", 32'(count_o), 4);
    chk("fill4_err", 32'(error_o), 0);

    // Overflow
    step(1, 0, 0, 8'h20, 12'h200);
    chk("ovf_count", 32'(count_o), 4);
    chk("ovf_err", 32'(error_o), 1);
    chk("ovf_head_addr", 32'(inst_addr_o), 32'h10);
    chk("ovf_head_data", 32'(inst_data_o), 32'h100);

    // Simultaneous on full
    step(1, 1, 0, 8'h14, 12'h104);
    chk("simf_count", 32'(count_o), 4);
    chk("simf_head_addr", 32'(inst_addr_o), 32'h11);
    chk("simf_head_data", 32'(inst_data_o), 32'h101);
    step(0, 1, 0, 8'h00, 12'h000);
    step(0, 1, 0, 8'h00, 12'h000);
    step(0, 1, 0, 8'h00, 12'h000);
    chk("simf_4th_addr", 32'(inst_addr_o), 32'h14);
    chk("simf_4th_data", 32'(inst_data_o), 32'h104);
    step(0, 1, 0, 8'h00, 12'h000);
    chk("drain_empty", 32'(empty_o), 1);
    step(0, 0, 1, 8'h00, 12'h000);
    chk("clr_err", 32'(error_o), 0);

    // Simultaneous on empty, then underflow
    step(1, 1, 0, 8'h30, 12'h300);
    chk("sime_valid", 32'(valid_o), 1);
    chk("sime_count", 32'(count_o), 1);
    chk("sime_err", 32'(error_o), 0);
    chk("sime_head", 32'(inst_data_o), 32'h300);
    step(0, 1, 0, 8'h00, 12'h000);
    chk("sime_deq_err", 32'(error_o), 0);
    step(0, 1, 0, 8'h00, 12'h000);
    chk("udf_err", 32'(error_o), 1);
    chk("udf_count", 32'(count_o), 0);

    // Clear with concurrent enqueue at count 3
    step(0, 0, 1, 8'h00, 12'h000);
    step(1, 0, 0, 8'h40, 12'h400);
    step(1, 0, 0, 8'h41, 12'h401);
    step(1, 0, 0, 8'h42, 12'h402);
    chk("pre_clr_count", 32'(count_o), 3);
    step(1, 0, 1, 8'h50, 12'h500);
    chk("clr_count", 32'(count_o), 0);
    chk("clr_empty", 32'(empty_o), 1);
    chk("clr_err2", 32'(error_o), 0);
    step(1, 0, 0, 8'h60, 12'h600);
    chk("post_clr_head", 32'(inst_addr_o), 32'h60);
    step(0, 1, 0, 8'h00, 12'h000);

    // Wrap stream: 20 entries with random enq/deq
    sent = 0;
    for (int c = 0; c < 400 && sent < 20; c++) begin
      r_e = ($urandom_range(0, 1) == 1) && (m_q.size() < DEPTH);
      r_d = ($urandom_range(0, 2) != 0) && (m_q.size() > 0);
      if (r_e) begin
        step(1, r_d, 0, 8'(8'h70 + sent), 12'(12'h700 + sent));
        sent++;
      end else begin
        step(0, r_d, 0, 8'h00, 12'h000);
      end
    end
    chk("stream_sent", 32'(sent), 20);
    for (int c = 0; c < 10 && m_q.size() > 0; c++) step(0, 1, 0, 8'h00, 12'h000);
    chk("stream_drained", 32'(empty_o), 1);
    chk("stream_err", 32'(error_o), 0);

    // Async reset mid-operation
    step(1, 0, 0, 8'h81, 12'h801);
    step(1, 0, 0, 8'h82, 12'h802);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_empty", 32'(empty_o), 1);
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_full", 32'(full_o), 0);
    chk("arst_af", 32'(almost_full_o), 0);
    chk("arst_err", 32'(error_o), 0);
    reset_i = 1'b0;
    step(1, 0, 0, 8'h77, 12'h777);
    chk("post_rst_count", 32'(count_o), 1);
    chk("post_rst_head", 32'(inst_addr_o), 32'h77);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fifo.md
INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The block SHALL have parameter I_WIDTH, default 12, meaning instruction data width.
REQ-002 The block SHALL have parameter A_WIDTH, default 8, meaning instruction address width.
REQ-003 The block SHALL have parameter LG_DEPTH, default 2, meaning log2 of the entry count; DEPTH = 2**LG_DEPTH, LG_DEPTH >= 1.
REQ-004 The block SHALL have parameter AF_MARGIN, default 1, meaning almost_full_o asserts when count >= DEPTH-AF_MARGIN.
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- inst_addr_i  in  A_WIDTH  address to enqueue
- inst_data_i  in  I_WIDTH  instruction to enqueue
- enque_i  in  1  enqueue request
- deque_i  in  1  dequeue request
- clear_i  in  1  synchronous flush
- inst_addr_o  out  A_WIDTH  head address
- inst_data_o  out  I_WIDTH  head instruction
- valid_o  out  1  head entry valid
- empty_o  out  1  count == 0
- full_o  out  1  count == DEPTH
- almost_full_o  out  1  count >= DEPTH-AF_MARGIN
- count_o  out  LG_DEPTH+1  current occupancy
- error_o  out  1  sticky misuse flag

Function
REQ-006 Capacity SHALL be all DEPTH entries, with no sacrificial slot; pointers SHALL carry LG_DEPTH+1 bits, with the MSB as the wrap bit.
REQ-007 Head outputs SHALL be first-word-fall-through: inst_addr_o and inst_data_o SHALL present the oldest entry combinationally; their values SHALL be don't-care while valid_o=0.
REQ-008 valid_o SHALL equal !empty_o.
REQ-009 An accepted enqueue (enque_i=1 and (!full_o or accepted dequeue in the same cycle)) SHALL write the entry at the write pointer and advance it by 1 at the next edge.
REQ-010 An accepted dequeue (deque_i=1 and !empty_o) SHALL advance the read pointer by 1 at the next edge.
REQ-011 With enque_i=1 and deque_i=1 while full, both SHALL be accepted; count SHALL be unchanged.
REQ-012 With enque_i=1 and deque_i=1 while empty, only the enqueue SHALL be accepted (no bypass); the new entry SHALL become visible the following cycle.
REQ-013 A rejected enqueue (full, no dequeue) SHALL leave storage and pointers unchanged and set error_o.
REQ-014 A rejected dequeue (empty) SHALL leave pointers unchanged and set error_o.
REQ-015 count_o SHALL be registered and update as count + accepted_enq - accepted_deq; it SHALL never exceed DEPTH or go below 0.
REQ-016 Pointers SHALL wrap modulo 2*DEPTH, with the low LG_DEPTH bits indexing storage.
REQ-017 clear_i SHALL take priority over enque_i and deque_i: at the next edge, pointers, count and error_o SHALL be set to 0, and no write is performed.
REQ-018 error_o SHALL remain 1 until reset_i or clear_i.
REQ-019 Latency SHALL be 1 cycle from enqueue edge to valid_o=1.
REQ-020 A simulation-only message SHALL be printed on each rejected enqueue or rejected dequeue, and excluded from synthesis.

Reset
REQ-021 reset_i=1 SHALL asynchronously force pointers=0, count_o=0, empty_o=1, valid_o=0, full_o=0, almost_full_o=0 (AF_MARGIN<DEPTH), error_o=0.
REQ-022 Storage arrays SHALL NOT be reset.
REQ-023 Assertion of reset_i mid-operation SHALL discard all entries; the first edge after deassertion SHALL accept a normal enqueue.

Structure
REQ-024 Package fifo_pkg SHALL hold the default width and depth constants and a function computing the count width (LG_DEPTH+1).
REQ-025 One sub-module fifo_ptr SHALL implement the (LG_DEPTH+1)-bit pointer register with async reset, sync clear and increment enable; inst_fifo SHALL instantiate it twice, once for read and once for write.

Verification
REQ-026 Fill scenario: reset, then enqueue 4 entries (addr 0x10..0x13, data 0x100..0x103) with LG_DEPTH=2 -> full_o=1, count_o=4, almost_full_o=1 after the 3rd, error_o=0.
REQ-027 Overflow scenario: on a full FIFO, enqueue 0x20/0x200 without dequeue -> count_o stays 4, error_o=1, head remains 0x10/0x100.
REQ-028 Simultaneous full scenario: on a full FIFO, enque_i=deque_i=1 with 0x14/0x104 -> count_o=4, head=0x11/0x101, the new entry is read out 4th.
REQ-029 Empty simultaneous and underflow scenario: on an empty FIFO, enque_i=deque_i=1 with 0x30/0x300 -> next cycle valid_o=1, count_o=1, error_o=0; a later deque on empty -> error_o=1.
REQ-030 Wrap scenario: stream 20 entries with random enq/deq -> the output order matches a scoreboard and count_o matches the model every cycle.
REQ-031 Clear and reset scenario: clear_i with enque_i=1 while count=3 -> count_o=0, empty_o=1, error_o=0; async reset_i pulsed between edges -> outputs return to reset values immediately.
